fetch_pipe_ctrl: RTL and testbench

FETCH_PIPE_CTRL -- requirements
Module: fetch_pipe_ctrl

---
 rtl/y86_pkg.sv | 39 +++
 rtl/pipe_reg.sv | 22 ++
 rtl/fetch_pipe_ctrl.sv | 93 +++++++++
 tb/tb_fetch_pipe_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 encodings used by the fetch/decode pipeline control.
//   icode constants HALT..POPQ, fetch status encodings, RNONE, and the
//   decode-register layout with its bubble value.
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] F_NONE   = 4'h0;
  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_e;
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [1:0]  stat;
  } d_reg_t;
  localparam int D_W = $bits(d_reg_t);
  localparam d_reg_t D_BUBBLE = '{
    icode: I_NOP, ifun: F_NONE, ra: RNONE, rb: RNONE,
    valc: 64'd0, valp: 64'd0, stat: STAT_AOK
  };
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: generic pipeline register with stall (hold) and bubble (load constant).
//   clock, reset_n : clock and async active-low reset (resets to BUBBLE)
//   i_stall        : hold current contents; overrides i_bubble
//   i_bubble       : load BUBBLE instead of i_d
//   i_d / o_q      : W-bit data in / registered data out
module pipe_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_stall,
  input  logic         i_bubble,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_q <= BUBBLE;
    else if (!i_stall) r_q <= i_bubble ? BUBBLE : i_d;
  assign o_q = r_q;
endmodule

// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: Y86 fetch PC selection, PC prediction and decode pipeline register.
//   clock, reset_n                    : clock, async active-low reset
//   f_icode/f_ifun/f_rA/f_rB/f_valC/f_valP/f_stat : fetch-stage fields
//   F_stall, D_stall, D_bubble        : hazard-unit controls
//   M_icode, M_Cnd, M_valA            : memory-stage branch resolution
//   W_icode, W_valM                   : write-back return address
//   PC                                : selected fetch address (combinational)
//   F_predPC                          : registered predicted PC
//   D_*                               : decode pipeline register outputs
//   f_locked                          : halt lock; only built with FETCH_HALT_LOCK_EN
module fetch_pipe_ctrl
  import y86_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [1:0]  f_stat,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] PC,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [1:0]  D_stat,
  output logic        f_locked
);
  logic        w_mispred;
  logic        w_ret;
  logic [63:0] w_pred_next;
  logic [63:0] r_pred_pc;
  d_reg_t      w_d_in;
  d_reg_t      w_d_q;
  // a not-taken jump reaching memory means the prediction was wrong; it outranks ret
  assign w_mispred   = (M_icode == I_JXX) && !M_Cnd;
  assign w_ret       = W_icode == I_RET;
  assign PC          = w_mispred ? M_valA : w_ret ? W_valM : r_pred_pc;
  assign w_pred_next = (f_icode == I_JXX || f_icode == I_CALL) ? f_valC : f_valP;
  assign F_predPC    = r_pred_pc;
`ifdef FETCH_HALT_LOCK_EN
  logic r_locked;
  // the lock arms only when a non-AOK status actually enters D, and a mispredict
  // both releases it and lets the redirected prediction load on the same edge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_pred_pc <= 64'd0;
      r_locked  <= 1'b0;
    end else begin
      if (!F_stall && (!r_locked || w_mispred)) r_pred_pc <= w_pred_next;
      if (w_mispred) r_locked <= 1'b0;
      else if (!D_stall && !D_bubble && f_stat != STAT_AOK) r_locked <= 1'b1;
    end
  assign f_locked = r_locked;
`else
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_pred_pc <= 64'd0;
    else if (!F_stall) r_pred_pc <= w_pred_next;
  assign f_locked = 1'b0;
`endif
  assign w_d_in = '{
    icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
    valc: f_valC, valp: f_valP, stat: f_stat
  };
  pipe_reg #(.W(D_W), .BUBBLE(D_BUBBLE)) u_d_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .i_stall (D_stall),
    .i_bubble(D_bubble),
    .i_d     (w_d_in),
    .o_q     (w_d_q)
  );
  assign D_icode = w_d_q.icode;
  assign D_ifun  = w_d_q.ifun;
  assign D_rA    = w_d_q.ra;
  assign D_rB    = w_d_q.rb;
  assign D_valC  = w_d_q.valc;
  assign D_valP  = w_d_q.valp;
  assign D_stat  = w_d_q.stat;
endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// tb_fetch_pipe_ctrl: scoreboard bench for fetch_pipe_ctrl.
module tb_fetch_pipe_ctrl;
`ifdef FETCH_HALT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [1:0]  stat;
  } dexp_t;
  typedef struct packed {
    dexp_t       d;
    logic [63:0] pred;
    logic        lock;
  } exp_t;
  localparam dexp_t BUB = '{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 2'b00};
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  f_icode = '0, f_ifun = '0, f_rA = '0, f_rB = '0;
  logic [63:0] f_valC = '0, f_valP = '0;
  logic [1:0]  f_stat = '0;
  logic        F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
  logic [3:0]  M_icode = '0;
  logic        M_Cnd = 1'b0;
  logic [63:0] M_valA = '0;
  logic [3:0]  W_icode = '0;
  logic [63:0] W_valM = '0;
  logic [63:0] PC, F_predPC, D_valC, D_valP;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [1:0]  D_stat;
  logic        f_locked;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  dexp_t m_d = BUB;
  logic [63:0] m_pred = '0;
  logic m_lock = 1'b0;
  logic [63:0] frozen;
  fetch_pipe_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .PC(PC), .F_predPC(F_predPC),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
    .f_locked(f_locked)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] exp_pc();
    if (M_icode == 4'd7 && !M_Cnd) return M_valA;
    if (W_icode == 4'd9) return W_valM;
    return m_pred;
  endfunction
  task automatic model_reset();
    m_d = BUB;
    m_pred = '0;
    m_lock = 1'b0;
    sb.delete();
  endtask
  task automatic step(input string tag);
    exp_t e;
    logic mis;
    mis = (M_icode == 4'd7) && !M_Cnd;
    e.d = D_stall ? m_d : D_bubble ? BUB : '{f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat};
    e.pred = (F_stall || (LOCK_EN && m_lock && !mis)) ? m_pred :
             (f_icode == 4'd7 || f_icode == 4'd8) ? f_valC : f_valP;
    e.lock = !LOCK_EN ? 1'b0 : mis ? 1'b0 :
             (!D_stall && !D_bubble && f_stat != 2'b00) ? 1'b1 : m_lock;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    m_d = e.d;
    m_pred = e.pred;
    m_lock = e.lock;
    chk({tag, ".D_icode"}, {60'd0, D_icode}, {60'd0, e.d.icode});
    chk({tag, ".D_ifun"}, {60'd0, D_ifun}, {60'd0, e.d.ifun});
    chk({tag, ".D_rA"}, {60'd0, D_rA}, {60'd0, e.d.ra});
    chk({tag, ".D_rB"}, {60'd0, D_rB}, {60'd0, e.d.rb});
    chk({tag, ".D_valC"}, D_valC, e.d.valc);
    chk({tag, ".D_valP"}, D_valP, e.d.valp);
    chk({tag, ".D_stat"}, {62'd0, D_stat}, {62'd0, e.d.stat});
    chk({tag, ".F_predPC"}, F_predPC, e.pred);
    chk({tag, ".f_locked"}, {63'd0, f_locked}, {63'd0, e.lock});
    chk({tag, ".PC"}, PC, exp_pc());
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, ".PC"}, PC, 64'd0);
    chk({tag, ".F_predPC"}, F_predPC, 64'd0);
    chk({tag, ".D_icode"}, {60'd0, D_icode}, 64'd1);
    chk({tag, ".D_ifun"}, {60'd0, D_ifun}, 64'd0);
    chk({tag, ".D_rA"}, {60'd0, D_rA}, 64'hF);
    chk({tag, ".D_rB"}, {60'd0, D_rB}, 64'hF);
    chk({tag, ".D_valP"}, D_valP, 64'd0);
    chk({tag, ".D_stat"}, {62'd0, D_stat}, 64'd0);
    chk({tag, ".f_locked"}, {63'd0, f_locked}, 64'd0);
  endtask
  initial begin
    #2 reset_n = 1'b0;
    #1 reset_checks("rst");
    model_reset();
    @(posedge clock);
    #1 reset_checks("rst_edge");
    #2 reset_n = 1'b1;
    f_icode = 4'd3; f_ifun = 4'd0; f_rA = 4'hF; f_rB = 4'd2; f_valC = 64'h55; f_valP = 64'h0A;
    step("irmovq");
    chk("irmovq.pred_const", F_predPC, 64'h0A);
    chk("irmovq.icode_const", {60'd0, D_icode}, 64'd3);
    f_icode = 4'd7; f_valC = 64'h40; f_valP = 64'h49;
    step("jxx");
    chk("jxx.pred_const", F_predPC, 64'h40);
    f_icode = 4'd1; f_valP = 64'h41;
    M_icode = 4'd7; M_Cnd = 1'b0; M_valA = 64'h13;
    #1 chk("mispred.PC", PC, 64'h13);
    M_Cnd = 1'b1;
    #1 chk("taken.PC", PC, 64'h40);
    W_icode = 4'd9; W_valM = 64'h80; M_Cnd = 1'b0; M_valA = 64'h20;
    #1 chk("mis_vs_ret.PC", PC, 64'h20);
    M_icode = 4'd0;
    #1 chk("ret.PC", PC, 64'h80);
    W_icode = 4'd0;
    f_icode = 4'd8; f_valC = 64'hFEDC_BA98_7654_3210; f_valP = 64'h8000_0000_0000_0001;
    step("call_wide");
    f_icode = 4'd6; f_ifun = 4'd3; f_valC = 64'h1; f_valP = 64'hFFFF_FFFF_FFFF_FFFF;
    step("opq_wide");
    D_stall = 1'b1; D_bubble = 1'b1;
    f_icode = 4'd5; f_ifun = 4'd0; f_rA = 4'd1; f_rB = 4'd4; f_valC = 64'h123; f_valP = 64'h200;
    step("stall_wins");
    chk("stall_wins.keep", {60'd0, D_icode}, 64'd6);
    D_stall = 1'b0;
    step("bubble");
    chk("bubble.icode", {60'd0, D_icode}, 64'd1);
    D_bubble = 1'b0; F_stall = 1'b1; f_valP = 64'h300;
    step("f_stall");
    F_stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      f_icode = 4'($urandom_range(0, 11)); f_ifun = 4'($urandom); f_rA = 4'($urandom); f_rB = 4'($urandom);
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom}; f_stat = 2'($urandom);
      F_stall = ($urandom_range(0, 3) == 0); D_stall = ($urandom_range(0, 3) == 0);
      D_bubble = ($urandom_range(0, 3) == 0);
      M_icode = $urandom_range(0, 1) ? 4'd7 : 4'd2; M_Cnd = 1'($urandom); M_valA = {$urandom, $urandom};
      W_icode = $urandom_range(0, 1) ? 4'd9 : 4'd0; W_valM = {$urandom, $urandom};
      step("rand");
    end
    F_stall = 0; D_stall = 0; D_bubble = 0; M_icode = 4'd0; W_icode = 4'd0;
    f_stat = 2'b00;
    step("flush");
    f_icode = 4'd0; f_stat = 2'b01; f_valP = 64'h500;
    step("halt_load");
    frozen = F_predPC;
    f_stat = 2'b00; f_icode = 4'd1;
    for (int i = 0; i < 3; i++) begin
      f_valP = 64'h600 + 64'(i);
      step("halt_hold");
`ifdef FETCH_HALT_LOCK_EN
      chk("halt_hold.frozen", F_predPC, frozen);
      chk("halt_hold.locked", {63'd0, f_locked}, 64'd1);
`endif
    end
    M_icode = 4'd7; M_Cnd = 1'b0; M_valA = 64'h700; f_valP = 64'h710;
    step("unlock");
    chk("unlock.locked", {63'd0, f_locked}, 64'd0);
    chk("unlock.pred", F_predPC, 64'h710);
    M_icode = 4'd0;
    F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1;
    #2 reset_n = 1'b0;
    #1 reset_checks("midrst");
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    f_icode = 4'd2; f_rA = 4'd3; f_rB = 4'd4; f_valP = 64'h902; f_stat = 2'b00;
    step("post_rst");
    chk("post_rst.pred", F_predPC, 64'h902);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
